signext_stream: RTL
===================

// Module: signext_stream
// PURPOSE
//  Streaming, multi-lane successor to the combinational sign extender. Each beat carries
//  LANES packed fields of runtime-selectable width i_len (1..N). Each field is sign- or
//  zero-extended to M bits, as selected by i_signed.
//  Two-stage valid/ready pipeline with full throughput; sits between packed-sample sources
//  and datapaths that need fixed-width operands.
// PARAMETERS
//  N      8   max source field width per lane, bits (N>=1)
//  M      16  output width per lane, bits (M>=N)
//  LANES  2   number of lanes per beat (LANES>=1)
// PORTS
//  i_clk     in   1          clock; all state updates on rising edge
//  i_rst_n   in   1          asynchronous, active-low reset
//  i_valid   in   1          input beat valid
//  o_ready   out  1          block accepts beat this cycle
//  i_data    in   LANES*N    lane k at [k*N +: N]; field is the low i_len bits
//  i_len     in   LW         field width, LW=$clog2(N+1); shared by all lanes of the beat
//  i_signed  in   1          1: sign-extend; 0: zero-extend
//  o_valid   out  1          output beat valid
//  i_ready   in   1          downstream accepts output
//  o_data    out  LANES*M    lane k at [k*M +: M]
//  o_err     out  1          beat had illegal i_len; qualified by o_valid
// BEHAVIOUR
//  - Reset (async assert, sync release): s1_valid=s2_valid=0, o_valid=0, o_data=0, o_err=0.
//    o_ready=1 from the first cycle after release.
//  - Handshake: transfer when valid&&ready on the same edge.
//    Once o_valid=1, o_data/o_err hold stable until i_ready=1.
//  - Advance rules:
//    adv2 = ~s2_valid | i_ready;  adv1 = ~s1_valid | adv2;  o_ready = adv1.
//    Combinational ready path, no skid.
//  - Stage 1 registers data, len, signed and a precomputed len-legal flag.
//    Stage 2 registers the extended result.
//  - Latency: 2 cycles from input accept to o_valid with no stall. Throughput: 1 beat/cycle.
//  - Extension per lane, for legal len L:
//    y[L-1:0] = x[L-1:0];  y[M-1:L] = i_signed ? {M-L{x[L-1]}} : 0.
//    Bits x[N-1:L] are ignored.
//  - L==N with M==N: pass-through.
//  - Illegal len (L==0 or L>N): all lanes output 0, o_err=1. The beat still flows and is
//    never dropped.
//  - Simultaneous accept and emit in one cycle is legal: both stages shift and occupancy
//    is unchanged.
//  - Ordering preserved. No beat is lost or duplicated under any i_ready pattern.
//  - i_rst_n low mid-stream: both stages are flushed immediately and o_valid drops
//    asynchronously. In-flight beats are discarded; none are emitted after release.
//  - Inputs are sampled only on accept. i_data/i_len/i_signed are don't-care while
//    i_valid=0 or o_ready=0.
// STRUCTURE
//  - signext_pkg: function len_w(N) returning $clog2(N+1); typedef ext_mode_e
//    {EXT_ZERO=0, EXT_SIGN=1}; function len_legal(len, N).
//  - Sub-module signext_lane #(N,M): combinational variable-width extender for one lane.
//    Instantiated LANES times via generate.
//  - Top: the two pipeline stages and the handshake logic (signext_stream).
// TESTING (N=8, M=16, LANES=2 unless noted)
//  1. Hold i_rst_n=0 for 3 cycles -> o_valid=0, o_data=0. After release o_ready=1.
//  2. Beat {lane1=8'h35, lane0=8'hFA}, len=4, signed=1 -> exactly 2 cycles later:
//     lane0=16'hFFFA, lane1=16'h0005, o_err=0.
//  3. lane0=8'h80, len=8: signed=1 -> 16'hFF80; signed=0 -> 16'h0080.
//     Second beat len=1, x=1, signed -> 16'hFFFF.
//  4. len=0, then len=9 -> o_data=0 and o_err=1 for both beats; the next legal beat has o_err=0.
//  5. Stream 6 beats with i_ready=0 on cycles 2-4:
//     - o_ready drops once both stages are full;
//     - o_data is stable while stalled;
//     - 6 beats emerge in order, no loss, no duplication.
//     Repeat with random i_valid/i_ready against a reference model.
//  6. Pull i_rst_n low with both stages full -> o_valid=0 at once, without waiting for a
//     clock edge. After release, no stale beat appears.
//  Also: exhaustive sweep of all len 0..15 x data 0..255 x signed, checked against the model.

Source files
------------

// File: rtl/signext_pkg.sv
// Shared types and helpers for the streaming sign/zero extender.
package signext_pkg;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_mode_e;

    function automatic int len_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic logic len_legal(input int unsigned len, input int unsigned n);
        return (len != 0) && (len <= n);
    endfunction

endpackage

// File: rtl/signext_lane.sv
// Combinational variable-width extender for one lane: low i_len bits kept, upper bits filled.
module signext_lane
    import signext_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 16
) (
    input  logic [N-1:0]        i_x,
    input  logic [len_w(N)-1:0] i_len,
    input  ext_mode_e           i_mode,
    input  logic                i_legal,
    output logic [M-1:0]        o_y
);

    localparam int LW = len_w(N);

    // An illegal width forces the whole lane to zero so the beat carries no stale bits.
    function automatic logic [M-1:0] ext_field(
        input logic [N-1:0]  x,
        input logic [LW-1:0] len,
        input ext_mode_e     mode,
        input logic          legal
    );
        logic [M-1:0] xw;
        logic [M-1:0] y;
        logic         msb;
        xw  = M'(x);
        y   = '0;
        msb = 1'b0;
        for (int b = 0; b < N; b++) begin
            if (b == int'(len) - 1) msb = x[b];
        end
        for (int b = 0; b < M; b++) begin
            if (b < int'(len)) y[b] = xw[b];
            else               y[b] = (mode == EXT_SIGN) ? msb : 1'b0;
        end
        return legal ? y : '0;
    endfunction

    assign o_y = ext_field(i_x, i_len, i_mode, i_legal);

endmodule

// File: rtl/signext_stream.sv
// Two-stage valid/ready pipeline extending LANES packed fields of width i_len to M bits each.
module signext_stream
    import signext_pkg::*;
#(
    parameter int N     = 8,
    parameter int M     = 16,
    parameter int LANES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [LANES*N-1:0]   i_data,
    input  logic [len_w(N)-1:0]  i_len,
    input  logic                 i_signed,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [LANES*M-1:0]   o_data,
    output logic                 o_err
);

    localparam int LW = len_w(N);

    logic                 r_vld_p1;
    logic [LANES*N-1:0]   r_data_p1;
    logic [LW-1:0]        r_len_p1;
    ext_mode_e            r_mode_p1;
    logic                 r_legal_p1;

    logic                 r_vld_p2;
    logic [LANES*M-1:0]   r_data_p2;
    logic                 r_err_p2;

    logic                 w_adv1;
    logic                 w_adv2;
    logic [LANES*M-1:0]   w_ext;

    // Ready is purely combinational back from the sink; there is no skid buffer.
    assign w_adv2  = ~r_vld_p2 | i_ready;
    assign w_adv1  = ~r_vld_p1 | w_adv2;
    assign o_ready = w_adv1;

    // Stage 1: capture the beat and the precomputed legality flag
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_p1 <= 1'b0;
        end else if (w_adv1) begin
            r_vld_p1 <= i_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_adv1 && i_valid) begin
            r_data_p1  <= i_data;
            r_len_p1   <= i_len;
            r_mode_p1  <= ext_mode_e'(i_signed);
            r_legal_p1 <= len_legal(int'(i_len), N);
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        signext_lane #(
            .N (N),
            .M (M)
        ) u_lane (
            .i_x     (r_data_p1[k*N +: N]),
            .i_len   (r_len_p1),
            .i_mode  (r_mode_p1),
            .i_legal (r_legal_p1),
            .o_y     (w_ext[k*M +: M])
        );
    end

    // Stage 2: register the extended result; held while the sink stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_err_p2  <= 1'b0;
        end else if (w_adv2) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= w_ext;
                r_err_p2  <= ~r_legal_p1;
            end
        end
    end

    assign o_valid = r_vld_p2;
    assign o_data  = r_data_p2;
    assign o_err   = r_err_p2;

endmodule
